// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: AXI4-Lite response codes and write-issue FSM states
package axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_AW, WAIT_W} wr_issue_state_t;
endpackage

// File: rtl/axi_lite_wr_master_if.sv
// axi_lite_wr_master_if: user command/response side plus AXI4-Lite write channels
interface axi_lite_wr_master_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic                cmd_valid, cmd_ready;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_data;
  logic [DATA_W/8-1:0] cmd_strb;
  logic                AWVALID, AWREADY;
  logic [ADDR_W-1:0]   AWADDR;
  logic                WVALID, WREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                BVALID, BREADY;
  logic [1:0]          BRESP;
  logic                rsp_valid;
  logic [1:0]          rsp_resp;
  logic                busy, timeout_err;
  modport master (
    input  cmd_valid, cmd_addr, cmd_data, cmd_strb, AWREADY, WREADY, BVALID, BRESP,
    output cmd_ready, AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, rsp_valid, rsp_resp,
           busy, timeout_err
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_data, cmd_strb, AWREADY, WREADY, BVALID, BRESP,
    input  cmd_ready, AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, rsp_valid, rsp_resp,
           busy, timeout_err
  );
endinterface

// File: rtl/axi_cmd_fifo.sv
// axi_cmd_fifo: synchronous FIFO, head entry presented from registered storage
module axi_cmd_fifo #(
  parameter int W     = 68,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  assign empty_o = wr_q == rd_q;
  assign full_o  = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
  assign rdata_o = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk)
    if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= wdata_i;
  always_ff @(posedge clk)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + (AW+1)'(push_i && !full_o);
      rd_q <= rd_q + (AW+1)'(pop_i && !empty_o);
    end
endmodule

// File: rtl/axi_lite_wr_master.sv
// axi_lite_wr_master: buffered AXI4-Lite write master with outstanding-B tracking.
// Optional B-wait watchdog enabled by defining AXI_WR_TIMEOUT_EN.
module axi_lite_wr_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_OUTST   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic                  ACLK,
  input logic                  ARESET,
  axi_lite_wr_master_if.master bus
);
  localparam int STRB_W = DATA_W/8;
  localparam int CW     = ADDR_W + DATA_W + STRB_W;
  localparam int OW     = $clog2(MAX_OUTST + 1);
  wr_issue_state_t   state_q, state_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic              bready_q, rsp_valid_q;
  logic [1:0]        rsp_resp_q;
  logic              full, empty, push, pop, aw_hs, w_hs, b_hs;
  logic [CW-1:0]     head;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [STRB_W-1:0] head_strb;
  assign bus.cmd_ready = !full && !ARESET;
  assign push = bus.cmd_valid && bus.cmd_ready;
  axi_cmd_fifo #(.W(CW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(ACLK), .rst(ARESET), .push_i(push), .pop_i(pop),
    .wdata_i({bus.cmd_addr, bus.cmd_data, bus.cmd_strb}),
    .rdata_o(head), .full_o(full), .empty_o(empty)
  );
  assign {head_addr, head_data, head_strb} = head;
  assign bus.AWVALID = state_q == ISSUE || state_q == WAIT_AW;
  assign bus.WVALID  = state_q == ISSUE || state_q == WAIT_W;
  assign bus.AWADDR  = bus.AWVALID ? head_addr : '0;
  assign bus.WDATA   = bus.WVALID ? head_data : '0;
  assign bus.WSTRB   = bus.WVALID ? head_strb : '0;
  assign bus.BREADY    = bready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_resp  = rsp_resp_q;
  assign bus.busy      = !empty || outst_q != '0;
  assign aw_hs = bus.AWVALID && bus.AWREADY;
  assign w_hs  = bus.WVALID && bus.WREADY;
  assign b_hs  = bus.BVALID && bready_q;
  // a push into an empty FIFO is visible at the head next cycle, so it may start issue now
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE:    if ((!empty || push) && outst_q < OW'(MAX_OUTST)) state_d = ISSUE;
      ISSUE: begin
        pop     = aw_hs && w_hs;
        state_d = pop ? IDLE : w_hs ? WAIT_AW : aw_hs ? WAIT_W : ISSUE;
      end
      WAIT_AW: begin
        pop     = aw_hs;
        state_d = aw_hs ? IDLE : WAIT_AW;
      end
      default: begin
        pop     = w_hs;
        state_d = w_hs ? IDLE : WAIT_W;
      end
    endcase
  end
  assign outst_d = outst_q + OW'(pop) - OW'(b_hs);
  always_ff @(posedge ACLK)
    if (ARESET) begin
      state_q     <= IDLE;
      outst_q     <= '0;
      bready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      state_q     <= state_d;
      outst_q     <= outst_d;
      bready_q    <= outst_d != '0;
      rsp_valid_q <= b_hs;
      if (b_hs) rsp_resp_q <= bus.BRESP;
    end
`ifdef AXI_WR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          terr_q;
  always_comb
    tcnt_d = b_hs ? '0 : (outst_q != '0 && tcnt_q != TW'(TIMEOUT_CYC-1)) ? tcnt_q + TW'(1) : tcnt_q;
  always_ff @(posedge ACLK)
    if (ARESET) begin
      tcnt_q <= '0;
      terr_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      terr_q <= terr_q || tcnt_d == TW'(TIMEOUT_CYC-1);
    end
  assign bus.timeout_err = terr_q;
`else
  assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_axi_lite_wr_master.sv
// tb_axi_lite_wr_master: randomized scoreboard bench for the buffered AXI4-Lite write master
module tb_axi_lite_wr_master;
  import axi_lite_pkg::*;
  localparam int AW = 32, DW = 32, SW = DW/8, DEPTH = 4, MAXO = 4, TO = 16;
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s;} cmd_t;
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;
  axi_lite_wr_master_if #(.ADDR_W(AW), .DATA_W(DW)) bif();
  axi_lite_wr_master #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .MAX_OUTST(MAXO),
                       .TIMEOUT_CYC(TO)) dut (.ACLK(ACLK), .ARESET(ARESET), .bus(bif));
  cmd_t to_push[$], cmds[$];
  int aw_n, w_n, b_n, rsp_n, p_cmd, p_aw, p_w, p_b, force_resp, cmp_n, err_n;
  logic [1:0] last_rsp, exp_rsp;
  bit rsp_exp, bhold, aw_pend, w_pend;
  logic [AW-1:0] aw_prev;
  logic [DW+SW-1:0] w_prev;

  function automatic int outst();
    return (aw_n < w_n ? aw_n : w_n) - b_n;
  endfunction
  function automatic int occ();
    return cmds.size() - (aw_n < w_n ? aw_n : w_n);
  endfunction
  function automatic cmd_t rnd_cmd();
    cmd_t c;
    c.a = $urandom; c.d = $urandom; c.s = 4'($urandom_range(15));
    return c;
  endfunction

  // one clock: drive at negedge, check and score handshakes, then check registered response
  task automatic cycle();
    @(negedge ACLK);
    bif.cmd_valid = to_push.size() > 0 && $urandom_range(99) < p_cmd;
    if (to_push.size() > 0) {bif.cmd_addr, bif.cmd_data, bif.cmd_strb} = to_push[0];
    bif.AWREADY = $urandom_range(99) < p_aw;
    bif.WREADY  = $urandom_range(99) < p_w;
    if (!bhold) begin
      bif.BVALID = outst() > 0 && $urandom_range(99) < p_b;
      bif.BRESP  = force_resp >= 0 ? 2'(force_resp) : 2'($urandom_range(3));
    end
    #1;
    cmp_n++;
    if (bif.cmd_ready !== (occ() < DEPTH)) begin
      err_n++; $display("FAIL cmd_ready: got %b exp %b", bif.cmd_ready, occ() < DEPTH);
    end
    cmp_n++;
    if (bif.busy !== (occ() > 0 || outst() > 0)) begin
      err_n++; $display("FAIL busy: got %b exp %b", bif.busy, occ() > 0 || outst() > 0);
    end
    cmp_n++;
    if (bif.BREADY !== (outst() > 0)) begin
      err_n++; $display("FAIL bready: got %b exp %b (outst %0d)", bif.BREADY, outst() > 0, outst());
    end
`ifndef AXI_WR_TIMEOUT_EN
    cmp_n++;
    if (bif.timeout_err !== 1'b0) begin
      err_n++; $display("FAIL timeout_err: got %b exp 0", bif.timeout_err);
    end
`endif
    if (aw_pend) begin
      cmp_n++;
      if (bif.AWVALID !== 1'b1 || bif.AWADDR !== aw_prev) begin
        err_n++; $display("FAIL aw_stable: got %b/%h exp 1/%h", bif.AWVALID, bif.AWADDR, aw_prev);
      end
    end
    if (w_pend) begin
      cmp_n++;
      if (bif.WVALID !== 1'b1 || {bif.WDATA, bif.WSTRB} !== w_prev) begin
        err_n++; $display("FAIL w_stable: got %b/%h exp 1/%h", bif.WVALID, {bif.WDATA, bif.WSTRB}, w_prev);
      end
    end
    aw_pend = bif.AWVALID && !bif.AWREADY; aw_prev = bif.AWADDR;
    w_pend  = bif.WVALID && !bif.WREADY;   w_prev  = {bif.WDATA, bif.WSTRB};
    if (bif.AWVALID && bif.AWREADY) begin
      cmp_n++;
      if (aw_n >= cmds.size()) begin
        err_n++; $display("FAIL aw_extra: got AW #%0d exp at most %0d", aw_n + 1, cmds.size());
      end else if (bif.AWADDR !== cmds[aw_n].a) begin
        err_n++; $display("FAIL awaddr: got %h exp %h", bif.AWADDR, cmds[aw_n].a);
      end
      aw_n++;
    end
    if (bif.WVALID && bif.WREADY) begin
      cmp_n++;
      if (w_n >= cmds.size()) begin
        err_n++; $display("FAIL w_extra: got W #%0d exp at most %0d", w_n + 1, cmds.size());
      end else if ({bif.WDATA, bif.WSTRB} !== {cmds[w_n].d, cmds[w_n].s}) begin
        err_n++; $display("FAIL wdata: got %h/%h exp %h/%h", bif.WDATA, bif.WSTRB, cmds[w_n].d, cmds[w_n].s);
      end
      w_n++;
    end
    if (bif.BVALID && bif.BREADY) begin
      b_n++; rsp_exp = 1; exp_rsp = bif.BRESP; bhold = 0;
    end else begin
      rsp_exp = 0; bhold = bif.BVALID;
    end
    if (bif.cmd_valid && bif.cmd_ready) cmds.push_back(to_push.pop_front());
    cmp_n++;
    if (outst() > MAXO || outst() < 0 || aw_n - w_n > 1 || w_n - aw_n > 1) begin
      err_n++; $display("FAIL outst: got %0d (aw %0d w %0d) exp 0..%0d", outst(), aw_n, w_n, MAXO);
    end
    @(posedge ACLK); #1;
    cmp_n++;
    if (bif.rsp_valid !== rsp_exp || (rsp_exp && bif.rsp_resp !== exp_rsp)) begin
      err_n++; $display("FAIL rsp: got %b/%0d exp %b/%0d", bif.rsp_valid, bif.rsp_resp, rsp_exp, exp_rsp);
    end
    if (bif.rsp_valid === 1'b1) begin rsp_n++; last_rsp = bif.rsp_resp; end
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESET = 1; bif.cmd_valid = 0; bif.AWREADY = 0; bif.WREADY = 0; bif.BVALID = 0; bif.BRESP = 0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESET = 0;
    to_push.delete(); cmds.delete();
    aw_n = 0; w_n = 0; b_n = 0; rsp_n = 0; bhold = 0; aw_pend = 0; w_pend = 0; rsp_exp = 0;
    p_cmd = 100; p_aw = 100; p_w = 100; p_b = 100; force_resp = -1;
  endtask

  task automatic drain();
    int k = 0;
    p_cmd = 100; p_aw = 100; p_w = 100; p_b = 100;
    while ((to_push.size() > 0 || occ() > 0 || outst() > 0) && k < 200) begin cycle(); k++; end
    cmp_n++;
    if (k >= 200) begin
      err_n++; $display("FAIL drain: got %0d pending exp 0 within 200 cycles", to_push.size() + occ() + outst());
    end
  endtask

  task automatic test_reset();
    ARESET = 1; bif.cmd_valid = 0; bif.AWREADY = 0; bif.WREADY = 0; bif.BVALID = 0; bif.BRESP = 0;
    repeat (2) @(posedge ACLK);
    #1;
    cmp_n++;
    if ({bif.cmd_ready, bif.AWVALID, bif.WVALID, bif.BREADY, bif.rsp_valid, bif.busy, bif.timeout_err} !== 7'b0) begin
      err_n++; $display("FAIL reset_outputs: got %b exp 0000000",
        {bif.cmd_ready, bif.AWVALID, bif.WVALID, bif.BREADY, bif.rsp_valid, bif.busy, bif.timeout_err});
    end
    do_reset();
    #1;
    cmp_n++;
    if (bif.cmd_ready !== 1'b1) begin
      err_n++; $display("FAIL ready_after_reset: got %b exp 1", bif.cmd_ready);
    end
  endtask

  task automatic test_single();
    int k = 0;
    do_reset();
    p_b = 0; force_resp = RESP_OKAY;
    to_push.push_back('{a: 32'h10, d: 32'hDEADBEEF, s: 4'hF});
    cycle();
    cmp_n++;
    if (bif.AWVALID !== 1'b1 || bif.WVALID !== 1'b1) begin
      err_n++; $display("FAIL first_issue: got aw %b w %b exp 1 1", bif.AWVALID, bif.WVALID);
    end
    repeat (3) cycle();
    p_b = 100;
    while (rsp_n == 0 && k < 10) begin cycle(); k++; end
    cycle();
    cmp_n++;
    if (aw_n != 1 || w_n != 1 || rsp_n != 1 || last_rsp !== RESP_OKAY || bif.busy !== 1'b0) begin
      err_n++; $display("FAIL single: got aw %0d w %0d rsp %0d/%0d busy %b exp 1 1 1/0 0",
        aw_n, w_n, rsp_n, last_rsp, bif.busy);
    end
  endtask

  task automatic test_w_first();
    do_reset();
    p_aw = 0;
    to_push.push_back(rnd_cmd());
    repeat (4) cycle();
    cmp_n++;
    if (bif.WVALID !== 1'b0 || bif.AWVALID !== 1'b1 || w_n != 1 || aw_n != 0 || occ() != 1) begin
      err_n++; $display("FAIL w_first: got wv %b awv %b w %0d aw %0d occ %0d exp 0 1 1 0 1",
        bif.WVALID, bif.AWVALID, w_n, aw_n, occ());
    end
    drain();
    cmp_n++;
    if (aw_n != 1 || w_n != 1 || rsp_n != 1) begin
      err_n++; $display("FAIL w_first_done: got aw %0d w %0d rsp %0d exp 1 1 1", aw_n, w_n, rsp_n);
    end
  endtask

  task automatic test_fifo_full();
    int k = 0;
    do_reset();
    p_aw = 0; p_w = 0;
    repeat (5) to_push.push_back(rnd_cmd());
    repeat (6) cycle();
    #1;
    cmp_n++;
    if (bif.cmd_ready !== 1'b0 || to_push.size() != 1 || cmds.size() != 4) begin
      err_n++; $display("FAIL fifo_full: got ready %b held %0d accepted %0d exp 0 1 4",
        bif.cmd_ready, to_push.size(), cmds.size());
    end
    p_aw = 100; p_w = 100;
    while (to_push.size() > 0 && k < 10) begin cycle(); k++; end
    cmp_n++;
    if (to_push.size() != 0 || aw_n < 1) begin
      err_n++; $display("FAIL fifo_resume: got held %0d issued %0d exp 0 >=1", to_push.size(), aw_n);
    end
    drain();
  endtask

  task automatic test_outst_limit();
    int k = 0;
    do_reset();
    p_b = 0;
    repeat (6) to_push.push_back(rnd_cmd());
    repeat (30) cycle();
    cmp_n++;
    if (aw_n != MAXO || w_n != MAXO || occ() != 2 || bif.AWVALID !== 1'b0) begin
      err_n++; $display("FAIL outst_limit: got aw %0d w %0d occ %0d awv %b exp 4 4 2 0",
        aw_n, w_n, occ(), bif.AWVALID);
    end
    p_b = 100; force_resp = RESP_SLVERR;
    while (rsp_n == 0 && k < 10) begin cycle(); k++; end
    cmp_n++;
    if (rsp_n != 1 || last_rsp !== RESP_SLVERR) begin
      err_n++; $display("FAIL slverr: got %0d rsp resp %0d exp 1 rsp resp 2", rsp_n, last_rsp);
    end
    force_resp = -1;
    drain();
    cmp_n++;
    if (aw_n != 6 || rsp_n != 6) begin
      err_n++; $display("FAIL outst_resume: got aw %0d rsp %0d exp 6 6", aw_n, rsp_n);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    p_b = 0;
    repeat (2) to_push.push_back(rnd_cmd());
    repeat (8) cycle();
    p_aw = 0;
    to_push.push_back(rnd_cmd());
    repeat (3) cycle();
    cmp_n++;
    if (bif.AWVALID !== 1'b1 || outst() != 2) begin
      err_n++; $display("FAIL mid_setup: got awv %b outst %0d exp 1 2", bif.AWVALID, outst());
    end
    @(negedge ACLK);
    ARESET = 1; bif.AWREADY = 0; bif.WREADY = 0; bif.BVALID = 0;
    @(posedge ACLK); #1;
    cmp_n++;
    if ({bif.AWVALID, bif.WVALID, bif.BREADY, bif.busy, bif.rsp_valid, bif.cmd_ready} !== 6'b0) begin
      err_n++; $display("FAIL reset_mid: got %b exp 000000",
        {bif.AWVALID, bif.WVALID, bif.BREADY, bif.busy, bif.rsp_valid, bif.cmd_ready});
    end
    @(negedge ACLK);
    ARESET = 0; bif.BVALID = 1; bif.BRESP = RESP_OKAY;
    repeat (3) begin
      @(posedge ACLK); #1;
      cmp_n++;
      if (bif.BREADY !== 1'b0 || bif.rsp_valid !== 1'b0 || bif.busy !== 1'b0) begin
        err_n++; $display("FAIL b_discard: got bready %b rsp %b busy %b exp 0 0 0",
          bif.BREADY, bif.rsp_valid, bif.busy);
      end
    end
    bif.BVALID = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int seg = 0; seg < 8; seg++) begin
      p_cmd = $urandom_range(20, 100); p_aw = $urandom_range(10, 100);
      p_w = $urandom_range(10, 100); p_b = $urandom_range(0, 100);
      for (int i = 0; i < 50; i++) begin
        if (to_push.size() < 3) to_push.push_back(rnd_cmd());
        cycle();
      end
    end
    drain();
    cmp_n++;
    if (rsp_n != cmds.size() || b_n != cmds.size()) begin
      err_n++; $display("FAIL random_total: got rsp %0d exp %0d", rsp_n, cmds.size());
    end
  endtask

`ifdef AXI_WR_TIMEOUT_EN
  task automatic test_timeout();
    int k = 0;
    do_reset();
    p_b = 0;
    to_push.push_back(rnd_cmd());
    while (bif.timeout_err !== 1'b1 && k < 40) begin cycle(); k++; end
    cmp_n++;
    if (k < 14 || k > 20) begin
      err_n++; $display("FAIL timeout_time: got %0d cycles exp 14..20", k);
    end
    p_b = 100;
    repeat (5) cycle();
    cmp_n++;
    if (bif.timeout_err !== 1'b1 || rsp_n != 1) begin
      err_n++; $display("FAIL timeout_sticky: got %b rsp %0d exp 1 1", bif.timeout_err, rsp_n);
    end
  endtask
`endif

  initial begin
    cmp_n = 0; err_n = 0;
    test_reset();
    test_single();
    test_w_first();
    test_fifo_full();
    test_outst_limit();
    test_reset_mid();
    test_random();
`ifdef AXI_WR_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish exp finish before 1000000");
    $fatal(1, "watchdog");
  end
endmodule
